xgs_spi_arbiter: RTL
====================

XGS_SPI_ARBITER -- requirements
Module: xgs_spi_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 15, sensor register address width; DATA_W, default 16, sensor register data width; TMO_CYC, default 4096, response timeout in sys_clk cycles.
REQ-002 The block SHALL use one clock, sys_clk; reset sys_reset_n SHALL be asynchronous and active-low.
REQ-003 Ports, listed as name, direction, width, meaning:
- sys_clk  in  1  clock
- sys_reset_n  in  1  async active-low reset
- hreq_valid  in  1  host (register file) request
- hreq_rnw  in  1  1=read, 0=write
- hreq_addr  in  ADDR_W  host address
- hreq_wdata  in  DATA_W  host write data
- hreq_ready  out  1  host request accepted
- hrsp_valid  out  1  host response strobe
- hrsp_rdata  out  DATA_W  host read data
- hrsp_err  out  1  host response timed out
- sreq_*/sreq_ready/srsp_*  same set for the sequencer requester
- spi_cmd_valid  out  1  command to SPI master
- spi_cmd_ready  in  1  SPI master accepts
- spi_cmd_rnw  out  1  command direction
- spi_cmd_addr  out  ADDR_W  command address
- spi_cmd_wdata  out  DATA_W  command write data
- spi_rsp_valid  in  1  SPI transaction complete
- spi_rsp_rdata  in  DATA_W  SPI read data
- arb_busy  out  1  transaction in flight
- arb_owner  out  1  0=host, 1=sequencer, valid while arb_busy

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT_RSP and RESP, and SHALL allow only one transaction outstanding at any time.
REQ-005 In IDLE with exactly one xreq_valid, the block SHALL grant that requester.
REQ-006 In IDLE with both valid, the block SHALL grant the requester not granted last (round-robin); after reset, last-granted SHALL be sequencer, so the host wins the first tie.
REQ-007 On grant, the block SHALL pulse xreq_ready for one cycle, register rnw/addr/wdata, set arb_owner, and go to ISSUE.
REQ-008 In ISSUE, spi_cmd_valid SHALL be 1 with the registered fields held stable until spi_cmd_ready, then the FSM SHALL go to WAIT_RSP.
REQ-009 In WAIT_RSP, spi_rsp_valid SHALL capture spi_rsp_rdata (reads) and go to RESP; a write SHALL also complete on spi_rsp_valid.
REQ-010 In RESP, the owner's xrsp_valid SHALL pulse for exactly one cycle with rdata (0 for writes) and err=0; the next state SHALL be IDLE.
REQ-011 Grant-to-response latency SHALL be 3 cycles plus SPI stall cycles; a new grant SHALL occur no earlier than the cycle after RESP.
REQ-012 A timeout counter SHALL run in ISSUE and WAIT_RSP; reaching TMO_CYC-1 SHALL force RESP with xrsp_err=1 and rdata=0.
REQ-013 An spi_rsp_valid arriving in the same cycle as the timeout SHALL take priority, giving a normal response with err=0.
REQ-014 spi_rsp_valid in IDLE, ISSUE or RESP SHALL be ignored.
REQ-015 Requester inputs SHALL be sampled only in IDLE; deasserting xreq_valid before grant SHALL withdraw the request with no side effect.
REQ-016 arb_busy SHALL be 1 in every state except IDLE.

Reset
REQ-017 While sys_reset_n=0, the following SHALL hold: state=IDLE; every ready, valid and err output =0; rdata, spi_cmd_* fields =0; arb_owner=0; timeout counter=0; last-granted=sequencer.
REQ-018 Reset asserted mid-transaction SHALL abort the transaction with no response pulse; after release, the FSM SHALL restart in IDLE.

Verification
REQ-019 Host write 0x3800<-0x0001 with spi_cmd_ready tied 1 and spi_rsp_valid 2 cycles after the command -> one SPI command with matching fields, hrsp_valid once, hrsp_err=0.
REQ-020 Host and sequencer valid in the same cycle after reset, repeated 4 times -> grant order H,S,H,S; no two commands overlap.
REQ-021 Sequencer read 0x3000 with SPI returning 0x0058 -> srsp_rdata=0x0058; the host side sees no hrsp_valid.
REQ-022 TMO_CYC=16 and no spi_rsp_valid -> hrsp_err=1, rdata=0 on cycle 16 after ISSUE entry; a subsequent late spi_rsp_valid is ignored.
REQ-023 spi_cmd_ready held 0 for 10 cycles -> spi_cmd_* stable throughout; the command is accepted on the first ready cycle.
REQ-024 Reset pulsed during WAIT_RSP -> all outputs 0 immediately; no response pulse; the next host request completes normally.

Source files
------------

// File: rtl/xgs_spi_arbiter_if.sv
// Bus bundle between the XGS SPI arbiter, its two requesters (host, sequencer) and the SPI master.
// "master" is the arbiter's own view; "slave" is the view of everything connected around it.
interface xgs_spi_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              hreq_valid;
  logic              hreq_rnw;
  logic [ADDR_W-1:0] hreq_addr;
  logic [DATA_W-1:0] hreq_wdata;
  logic              hreq_ready;
  logic              hrsp_valid;
  logic [DATA_W-1:0] hrsp_rdata;
  logic              hrsp_err;

  logic              sreq_valid;
  logic              sreq_rnw;
  logic [ADDR_W-1:0] sreq_addr;
  logic [DATA_W-1:0] sreq_wdata;
  logic              sreq_ready;
  logic              srsp_valid;
  logic [DATA_W-1:0] srsp_rdata;
  logic              srsp_err;

  logic              spi_cmd_valid;
  logic              spi_cmd_ready;
  logic              spi_cmd_rnw;
  logic [ADDR_W-1:0] spi_cmd_addr;
  logic [DATA_W-1:0] spi_cmd_wdata;
  logic              spi_rsp_valid;
  logic [DATA_W-1:0] spi_rsp_rdata;

  modport master (
    input  hreq_valid, hreq_rnw, hreq_addr, hreq_wdata,
    output hreq_ready, hrsp_valid, hrsp_rdata, hrsp_err,
    input  sreq_valid, sreq_rnw, sreq_addr, sreq_wdata,
    output sreq_ready, srsp_valid, srsp_rdata, srsp_err,
    output spi_cmd_valid, spi_cmd_rnw, spi_cmd_addr, spi_cmd_wdata,
    input  spi_cmd_ready, spi_rsp_valid, spi_rsp_rdata
  );

  modport slave (
    output hreq_valid, hreq_rnw, hreq_addr, hreq_wdata,
    input  hreq_ready, hrsp_valid, hrsp_rdata, hrsp_err,
    output sreq_valid, sreq_rnw, sreq_addr, sreq_wdata,
    input  sreq_ready, srsp_valid, srsp_rdata, srsp_err,
    input  spi_cmd_valid, spi_cmd_rnw, spi_cmd_addr, spi_cmd_wdata,
    output spi_cmd_ready, spi_rsp_valid, spi_rsp_rdata
  );
endinterface

// File: rtl/xgs_spi_arbiter.sv
// Round-robin arbiter granting the host or the sequencer access to a single SPI master,
// with one transaction outstanding and a response timeout.
module xgs_spi_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 4096
) (
  input  logic               sys_clk,
  input  logic               sys_reset_n,
  xgs_spi_arbiter_if.master  bus,
  output logic               arb_busy,
  output logic               arb_owner
);

  localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_grant_h;
  logic              w_grant_s;
  logic              w_tmo;
  logic              w_hrsp_valid;
  logic              w_srsp_valid;

  logic              r_hreq_ready;
  logic              r_sreq_ready;
  logic              r_owner;
  logic              r_last_seq;
  logic              r_rnw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_tmo_cnt;

  assign w_tmo = (r_tmo_cnt == TMO_LAST);

  // Ties go to whoever was not granted last; a lone requester always wins.
  always_comb begin
    w_next    = r_state;
    w_grant_h = 1'b0;
    w_grant_s = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.hreq_valid && (!bus.sreq_valid || r_last_seq)) begin
          w_grant_h = 1'b1;
          w_next    = ISSUE;
        end else if (bus.sreq_valid) begin
          w_grant_s = 1'b1;
          w_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (w_tmo)                  w_next = RESP;
        else if (bus.spi_cmd_ready) w_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (bus.spi_rsp_valid || w_tmo) w_next = RESP;
      end
      RESP: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state      <= IDLE;
      r_hreq_ready <= 1'b0;
      r_sreq_ready <= 1'b0;
      r_owner      <= 1'b0;
      r_last_seq   <= 1'b1;
      r_rnw        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_tmo_cnt    <= '0;
    end else begin
      r_state      <= w_next;
      r_hreq_ready <= w_grant_h;
      r_sreq_ready <= w_grant_s;
      if (w_grant_h || w_grant_s) begin
        r_owner    <= w_grant_s;
        r_last_seq <= w_grant_s;
        r_rnw      <= w_grant_s ? bus.sreq_rnw   : bus.hreq_rnw;
        r_addr     <= w_grant_s ? bus.sreq_addr  : bus.hreq_addr;
        r_wdata    <= w_grant_s ? bus.sreq_wdata : bus.hreq_wdata;
        r_rdata    <= '0;
        r_err      <= 1'b0;
        r_tmo_cnt  <= '0;
      end
      if (r_state == ISSUE || r_state == WAIT_RSP) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      // A response landing on the timeout cycle still counts as a normal completion.
      if (r_state == WAIT_RSP && bus.spi_rsp_valid) begin
        r_rdata <= r_rnw ? bus.spi_rsp_rdata : '0;
        r_err   <= 1'b0;
      end else if ((r_state == ISSUE || r_state == WAIT_RSP) && w_tmo) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign w_hrsp_valid      = (r_state == RESP) && !r_owner;
  assign w_srsp_valid      = (r_state == RESP) &&  r_owner;

  assign bus.hreq_ready    = r_hreq_ready;
  assign bus.hrsp_valid    = w_hrsp_valid;
  assign bus.hrsp_rdata    = w_hrsp_valid ? r_rdata : '0;
  assign bus.hrsp_err      = w_hrsp_valid & r_err;

  assign bus.sreq_ready    = r_sreq_ready;
  assign bus.srsp_valid    = w_srsp_valid;
  assign bus.srsp_rdata    = w_srsp_valid ? r_rdata : '0;
  assign bus.srsp_err      = w_srsp_valid & r_err;

  assign bus.spi_cmd_valid = (r_state == ISSUE);
  assign bus.spi_cmd_rnw   = r_rnw;
  assign bus.spi_cmd_addr  = r_addr;
  assign bus.spi_cmd_wdata = r_wdata;

  assign arb_busy          = (r_state != IDLE);
  assign arb_owner         = r_owner;

endmodule
